// File: rtl/outpkt_header_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : outpkt_header_tx_pkg
//  Description : Shared types and constants for the output packet transmitter:
//                state encoding, framing lengths, descriptor layout and the
//                header byte lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package outpkt_header_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_HCS   = 3'd2,
        ST_DATA  = 3'd3,
        ST_DCS   = 3'd4,
        ST_ERROR = 3'd5
    } outpkt_state_e;

    localparam int unsigned OUTPKT_HDR_LEN  = 10;
    localparam int unsigned OUTPKT_CSUM_LEN = 4;

    typedef struct packed {
        logic [7:0]  ptype;
        logic [15:0] id;
        logic [23:0] len;
    } outpkt_desc_t;

    // Header byte at position idx (0..9) for a given descriptor.
    function automatic logic [7:0] outpkt_hdr_byte(input logic [7:0] version,
                                                   input outpkt_desc_t d,
                                                   input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = version;
            4'd1:    b = d.ptype;
            4'd4:    b = d.len[7:0];
            4'd5:    b = d.len[15:8];
            4'd6:    b = d.len[23:16];
            4'd8:    b = d.id[7:0];
            4'd9:    b = d.id[15:8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/outpkt_checksum.sv
`default_nettype none
// ============================================================================
//  Module      : outpkt_checksum
//  Description : Little-endian word-packing 32-bit checksum. Bytes fed with
//                byte_valid_i; load_i latches the inverted sum including the
//                byte presented in the same cycle; clr_i restarts the sum.
//                Built only when OUTPKT_CHECKSUM_EN is defined, otherwise the
//                result is constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module outpkt_checksum
    import outpkt_header_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        clr_i,
    input  logic        load_i,
    output logic [31:0] csum_o
);

`ifdef OUTPKT_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] word_q, word_d;
    logic [31:0] csum_q, csum_d;
    logic [1:0]  pos_q, pos_d;
    logic [31:0] w_word_new;
    logic [31:0] w_sum;

    // Merge the incoming byte into the partial word and form the running total.
    always_comb begin
        w_word_new = word_q | ({24'd0, byte_i} << {pos_q, 3'b000});
        w_sum      = acc_q + (byte_valid_i ? w_word_new : word_q);
        acc_d      = acc_q;
        word_d     = word_q;
        pos_d      = pos_q;
        csum_d     = csum_q;
        if (byte_valid_i) begin
            if (pos_q == 2'd3) begin
                acc_d  = w_sum;
                word_d = 32'd0;
                pos_d  = 2'd0;
            end else begin
                word_d = w_word_new;
                pos_d  = pos_q + 2'd1;
            end
        end
        if (load_i) begin
            csum_d = ~w_sum;
        end
        if (clr_i) begin
            acc_d  = 32'd0;
            word_d = 32'd0;
            pos_d  = 2'd0;
        end
    end

    // Accumulator, partial word and latched result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= 32'd0;
            word_q <= 32'd0;
            pos_q  <= 2'd0;
            csum_q <= 32'd0;
        end else begin
            acc_q  <= acc_d;
            word_q <= word_d;
            pos_q  <= pos_d;
            csum_q <= csum_d;
        end
    end

    assign csum_o = csum_q;
`else
    logic w_unused;
    assign w_unused = ^{clk_i, rst_i, byte_i, byte_valid_i, clr_i, load_i};
    assign csum_o   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: rtl/outpkt_header_tx.sv
`default_nettype none
// ============================================================================
//  Module      : outpkt_header_tx
//  Description : Byte-serial packet framer. Emits a 10-byte header, header
//                checksum, payload and payload checksum onto a registered
//                byte stream with a valid/read handshake. Checksum logic is
//                present when OUTPKT_CHECKSUM_EN is defined; otherwise the
//                checksum bytes are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module outpkt_header_tx
    import outpkt_header_tx_pkg::*;
#(
    parameter int unsigned VERSION      = 1,
    parameter int unsigned PKT_MAX_LEN  = 65536,
    parameter int unsigned PKT_MAX_TYPE = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [7:0]  pkt_type,
    input  logic [15:0] pkt_id,
    input  logic [23:0] pkt_len,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_rd,
    output logic        err,
    output logic        busy
);

    outpkt_state_e state_q, state_d;
    logic [23:0]   cnt_q, cnt_d;
    outpkt_desc_t  desc_q, desc_d;
    outpkt_desc_t  w_desc_in;
    logic [7:0]    dout_q, dout_d;
    logic          dv_q, dv_d;
    logic          err_q, err_d;
    logic          w_adv;
    logic          w_bad;
    logic [7:0]    w_hdr_byte;
    logic [7:0]    w_csum_byte;
    logic [31:0]   w_csum;
    logic          cs_byte_v;
    logic [7:0]    cs_byte;
    logic          cs_load;

    // The output register may take a new byte when empty or being read.
    assign w_adv      = ~dv_q | dout_rd;
    assign w_desc_in  = '{ptype: pkt_type, id: pkt_id, len: pkt_len};
    assign w_bad      = (pkt_type == 8'd0) || ({24'd0, pkt_type} > PKT_MAX_TYPE) ||
                        (pkt_len == 24'd0) || ({8'd0, pkt_len} > PKT_MAX_LEN);
    assign w_hdr_byte  = outpkt_hdr_byte(8'(VERSION), desc_q, cnt_q[3:0]);
    assign w_csum_byte = w_csum[{cnt_q[1:0], 3'b000} +: 8];

    assign hdr_ready  = (state_q == ST_IDLE);
    assign din_ready  = (state_q == ST_DATA) & w_adv;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_ERROR);

    // Loading the last covered byte also clears the sum, so the payload
    // checksum starts fresh once the header checksum is latched.
    outpkt_checksum u_csum (
        .clk_i        (CLK),
        .rst_i        (RST),
        .byte_i       (cs_byte),
        .byte_valid_i (cs_byte_v),
        .clr_i        (cs_load),
        .load_i       (cs_load),
        .csum_o       (w_csum)
    );

    // Next-state, output byte selection and checksum strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        desc_d    = desc_q;
        dout_d    = dout_q;
        dv_d      = dv_q;
        err_d     = err_q;
        cs_byte_v = 1'b0;
        cs_byte   = 8'h00;
        cs_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_adv) begin
                    dv_d = 1'b0;
                end
                if (hdr_valid) begin
                    if (w_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        desc_d  = w_desc_in;
                        state_d = ST_HDR;
                        cnt_d   = 24'd0;
                        // Emit the version byte immediately when the output is free.
                        if (w_adv) begin
                            dout_d    = 8'(VERSION);
                            dv_d      = 1'b1;
                            cs_byte_v = 1'b1;
                            cs_byte   = 8'(VERSION);
                            cnt_d     = 24'd1;
                        end
                    end
                end
            end
            ST_HDR: begin
                if (w_adv) begin
                    dout_d    = w_hdr_byte;
                    dv_d      = 1'b1;
                    cs_byte_v = 1'b1;
                    cs_byte   = w_hdr_byte;
                    if (cnt_q == 24'(OUTPKT_HDR_LEN - 1)) begin
                        cs_load = 1'b1;
                        cnt_d   = 24'd0;
                        state_d = ST_HCS;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
            end
            ST_HCS, ST_DCS: begin
                if (w_adv) begin
                    dout_d = w_csum_byte;
                    dv_d   = 1'b1;
                    if (cnt_q == 24'(OUTPKT_CSUM_LEN - 1)) begin
                        cnt_d   = 24'd0;
                        state_d = (state_q == ST_HCS) ? ST_DATA : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_adv) begin
                    if (din_valid) begin
                        dout_d    = din;
                        dv_d      = 1'b1;
                        cs_byte_v = 1'b1;
                        cs_byte   = din;
                        if (cnt_q == desc_q.len - 24'd1) begin
                            cs_load = 1'b1;
                            cnt_d   = 24'd0;
                            state_d = ST_DCS;
                        end else begin
                            cnt_d = cnt_q + 24'd1;
                        end
                    end else begin
                        dv_d = 1'b0;
                    end
                end
            end
            ST_ERROR: begin
                if (w_adv) begin
                    dv_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, descriptor and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 24'd0;
            desc_q  <= '0;
            dout_q  <= 8'h00;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            desc_q  <= desc_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/outpkt_header_tx.md
# outpkt_header_tx

Byte-serial transmitter for the versioned input-packet protocol, built from the FPGA side rather than received by it. It takes a packet descriptor (type, id, length) and a payload byte stream and emits the framed packet byte by byte:

- 10-byte header;
- 4-byte header checksum;
- `len` payload bytes;
- 4-byte payload checksum.

It sits between the result/test generators and the USB/host output FIFO. Its output is byte-for-byte what the packet receiver accepts.

## Interface
- `VERSION`, default 1: value emitted in header byte 0; must be nonzero.
- `PKT_MAX_LEN`, default 65536: largest legal payload length in bytes.
- `PKT_MAX_TYPE`, default 1: largest legal packet type; type 0 is illegal.
- `CLK` input, 1 bit: the single clock.
- `RST` input, 1 bit: synchronous, active-high reset.
- `hdr_valid` input, 1 bit: descriptor fields are valid.
- `hdr_ready` output, 1 bit: block is IDLE and will take a descriptor.
- `pkt_type` input, 8 bits: packet type.
- `pkt_id` input, 16 bits: packet id.
- `pkt_len` input, 24 bits: payload length in bytes, excluding header and checksums.
- `din` input, 8 bits: payload byte.
- `din_valid` input, 1 bit: `din` is valid.
- `din_ready` output, 1 bit: payload byte is consumed this cycle.
- `dout` output, 8 bits: output byte.
- `dout_valid` output, 1 bit: `dout` is valid.
- `dout_rd` input, 1 bit: downstream takes `dout` this cycle.
- `err` output, 1 bit: sticky descriptor error.
- `busy` output, 1 bit: a packet is in flight.

## Operation
**Packet byte order**
- Header bytes: VERSION, type, 0x00, 0x00, len[7:0], len[15:8], len[23:16], 0x00, id[7:0], id[15:8].
- Then the header checksum (4 bytes), then the payload, then the payload checksum (4 bytes).

**Checksum**
- Bytes are packed little-endian into 32-bit words. A trailing partial word is zero-padded.
- The words are summed mod 2^32 and the sum is inverted. The result is emitted LSB first.
- Header checksum covers the 10 header bytes only.
- Payload checksum covers payload bytes only; the accumulator clears after the header checksum is sent.

**States**
- IDLE → HDR when `hdr_valid & hdr_ready` and the descriptor is legal. The descriptor is latched.
- HDR: byte index 0..9, one byte per accepted output; → HCS after byte 9.
- HCS: checksum bytes 0..3; → DATA after byte 3.
- DATA: passes `len` bytes from `din` to `dout`; → DCS after the last byte.
- DCS: checksum bytes 0..3; → IDLE after byte 3.
- ERROR: entered from IDLE on an illegal descriptor.

**Descriptor legality**
- A descriptor is illegal if any of these hold: `pkt_type == 0`, `pkt_type > PKT_MAX_TYPE`, `pkt_len == 0`, `pkt_len > PKT_MAX_LEN`.
- An illegal descriptor is consumed with `hdr_ready` high that cycle. Then `err` is set, the block enters ERROR, and no bytes are emitted.
- ERROR is left only by `RST`.

**Handshakes and flags**
- `din_ready = (state == DATA) & (~dout_valid | dout_rd)`. The block never takes `din` outside DATA.
- `busy` is high in every state except IDLE and ERROR.

## Timing
- `dout` and `dout_valid` are registered. A byte advances only when `~dout_valid | dout_rd`.
- With `dout_rd` and `din_valid` held high, the packet streams with no bubbles. First byte appears the cycle after descriptor acceptance; one byte per cycle thereafter; 18+len bytes in 18+len cycles.
- Back-to-back packets: `hdr_ready` rises in the cycle DCS byte 3 is loaded, so a new VERSION byte can follow with no gap.
- Checksum value:
  - Formed combinationally from accumulator + partial word when the last covered byte is loaded.
  - Latched into a 32-bit register.
  - No extra cycle.
- `dout_valid` high with `dout_rd` low holds `dout` and all state unchanged. `din` stalls with it.
- `din_valid` low in DATA: `dout_valid` drops after the pending byte drains, and the payload counter holds.
- Reset values:
  - `dout_valid=0`, `dout=0`, `hdr_ready=1` (combinational from IDLE), `din_ready=0`, `err=0`, `busy=0`.
  - State IDLE; accumulator and counters 0.
- `RST` mid-packet aborts immediately. The partial packet is not completed, and the next packet starts from a clean header.

## Configuration
- `OUTPKT_CHECKSUM_EN` defined: checksums are computed as above.
- Undefined:
  - Accumulator and adder are removed.
  - HCS/DCS still emit 4 bytes each, all 0x00. Receivers built with checksum checking disabled accept this.
  - Framing and timing are identical.

## Structure
- The shared package holds:
  - State encoding constants (IDLE, HDR, HCS, DATA, DCS, ERROR);
  - `OUTPKT_HDR_LEN = 10`;
  - `OUTPKT_CSUM_LEN = 4`;
  - a descriptor typedef {type, id, len}.
- One sub-module, `outpkt_checksum`:
  - byte-in, clear, and load strobes;
  - 32-bit accumulator with word packing;
  - inverted-result output.

## Test plan
- VERSION=2, type=1, id=0x1234, len=1, data 0xAB → dout 02 01 00 00 01 00 00 00 34 12 C8 EC FF FF AB 54 FF FF FF, 19 consecutive cycles.
- Same packet with `dout_rd` toggling 1/0 → identical byte sequence, `dout` stable while unread, no extra `din_ready`.
- Two descriptors back-to-back, len=4 each → second VERSION byte directly follows first DCS byte 3.
- `pkt_len=0`, or `pkt_type=0`, or `pkt_len=PKT_MAX_LEN+1` → `err=1`, no `dout_valid`, `hdr_ready` low until `RST`.
- `RST` asserted at payload byte 3 of len=8 → next cycle `dout_valid=0`, `busy=0`; a following packet emits a correct header and checksums.
- Macro undefined, first packet → checksum bytes all 0x00, other bytes unchanged.
